// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   - receiver FSM state encoding
//   - 8N1 frame constants: line idle level, start bit level, stop bit level
//   - default payload width
package uart_pkg;

    localparam int   DEFAULT_DATA_BITS = 8;

    // 8N1 framing: idle-high line, one low start bit, payload, one high stop bit.
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side consumer handshake of the UART receiver.
//   rx_data   : received word held in the output buffer
//   rx_valid  : rx_data holds an unconsumed word
//   rx_ready  : consumer accepts rx_data when rx_valid & rx_ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, new word dropped because the buffer was full
// master = receiver side, slave = consumer side.
interface uart_rx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk : destination clock
//   RST : synchronous active-high reset, loads RESET_VAL into both stages
//   d   : asynchronous input bits
//   q   : synchronized output bits
module sync_2ff
    import uart_pkg::*;
#(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = LINE_IDLE
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic meta_reg;
        logic sync_reg;

        always_ff @(posedge clk) begin
            if (RST) begin
                meta_reg <= RESET_VAL;
                sync_reg <= RESET_VAL;
            end else begin
                meta_reg <= d[gi];
                sync_reg <= meta_reg;
            end
        end

        assign q[gi] = sync_reg;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller.
//   clk      : system clock, all logic on rising edge
//   RST      : synchronous active-high reset
//   rx_pin   : asynchronous serial line, idle high
//   clk_uart : one-cycle mid-bit tick from the external baud generator
//   bps_en   : enables the baud generator while a frame is in progress
//   rx_if    : consumer handshake (rx_data/rx_valid/rx_ready/frame_err/overrun)
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  rx_pin,
    input  logic                  clk_uart,
    output logic                  bps_en,
    uart_rx_ctrl_if.master        rx_if
);

    localparam int              IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_sync;
    logic                 rx_prev_reg;

    rx_state_t            state_reg,     state_next;
    logic [IDX_W-1:0]     idx_reg,       idx_next;
    logic [DATA_BITS-1:0] shift_reg,     shift_next;
    logic                 done_reg,      done_next;
    logic                 frame_err_reg, frame_err_next;
    logic                 brk_reg,       brk_next;

    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 overrun_reg;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk (clk),
        .RST (RST),
        .d   (rx_pin),
        .q   (rx_sync)
    );

    // FSM and frame shift register.
    always_ff @(posedge clk) begin
        if (RST) begin
            rx_prev_reg   <= LINE_IDLE;
            state_reg     <= IDLE;
            idx_reg       <= '0;
            shift_reg     <= '0;
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            brk_reg       <= 1'b0;
        end else begin
            rx_prev_reg   <= rx_sync;
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            done_reg      <= done_next;
            frame_err_reg <= frame_err_next;
            brk_reg       <= brk_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        shift_next     = shift_reg;
        done_next      = 1'b0;
        frame_err_next = 1'b0;
        brk_next       = brk_reg;

        case (state_reg)
            IDLE: begin
                idx_next = '0;
                // After a bad stop bit the line may be held low (break);
                // refuse new starts until it has been seen idle again.
                if (brk_reg) begin
                    if (rx_sync == LINE_IDLE) begin
                        brk_next = 1'b0;
                    end
                end else if (rx_prev_reg == LINE_IDLE && rx_sync == START_BIT) begin
                    state_next = START;
                end
            end
            START: begin
                if (clk_uart) begin
                    if (rx_sync != START_BIT) begin
                        state_next = IDLE;          // glitch, not a real start bit
                    end else begin
                        state_next = DATA;
                        idx_next   = '0;
                    end
                end
            end
            DATA: begin
                if (clk_uart) begin
                    // LSB arrives first, so shift in from the top.
                    shift_next = {rx_sync, shift_reg[DATA_BITS-1:1]};
                    if (idx_reg == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (clk_uart) begin
                    state_next = IDLE;
                    if (rx_sync == STOP_BIT) begin
                        done_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                        brk_next       = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output buffer: loads one cycle after the stop tick. A completion that
    // coincides with the consumer taking the old word refills the buffer.
    always_ff @(posedge clk) begin
        if (RST) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (done_reg) begin
                if (!valid_reg || rx_if.rx_ready) begin
                    data_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && rx_if.rx_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign bps_en          = (state_reg != IDLE);
    assign rx_if.rx_data   = data_reg;
    assign rx_if.rx_valid  = valid_reg;
    assign rx_if.frame_err = frame_err_reg;
    assign rx_if.overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural baud generator
// (BPS_PARA clocks per bit, tick at mid-bit) and a 50 MHz clock.
module tb_uart_rx_ctrl;

    localparam int BPS_PARA = 16;

    logic clk = 1'b0;
    logic RST = 1'b1;
    logic rx_pin = 1'b1;
    logic clk_uart = 1'b0;
    logic bps_en;

    uart_rx_ctrl_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_ctrl #(.DATA_BITS(8)) dut (
        .clk      (clk),
        .RST      (RST),
        .rx_pin   (rx_pin),
        .clk_uart (clk_uart),
        .bps_en   (bps_en),
        .rx_if    (rx_if)
    );

    always #10 clk = ~clk;

    // Baud generator: counter cleared while disabled, tick at half period.
    int bcnt = 0;
    always @(posedge clk) begin
        if (!bps_en) begin
            bcnt     <= 0;
            clk_uart <= 1'b0;
        end else begin
            bcnt     <= (bcnt == BPS_PARA - 1) ? 0 : bcnt + 1;
            clk_uart <= (bcnt == BPS_PARA / 2 - 1);
        end
    end

    // Event monitor, sampled on the falling edge.
    int cyc = 0;
    int valid_rises = 0, ferr_rises = 0, ferr_hi = 0, ovr_rises = 0, ovr_hi = 0;
    int bps_rises = 0, bps_rise_cyc = 0, bps_fall_cyc = 0, valid_rise_cyc = 0;
    logic valid_prev = 1'b0, ferr_prev = 1'b0, ovr_prev = 1'b0, bps_prev = 1'b0;
    logic [7:0] acc_q[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rx_if.rx_valid === 1'b1 && valid_prev !== 1'b1) begin
            valid_rises    = valid_rises + 1;
            valid_rise_cyc = cyc;
        end
        if (rx_if.frame_err === 1'b1) ferr_hi = ferr_hi + 1;
        if (rx_if.frame_err === 1'b1 && ferr_prev !== 1'b1) ferr_rises = ferr_rises + 1;
        if (rx_if.overrun === 1'b1) ovr_hi = ovr_hi + 1;
        if (rx_if.overrun === 1'b1 && ovr_prev !== 1'b1) ovr_rises = ovr_rises + 1;
        if (bps_en === 1'b1 && bps_prev !== 1'b1) begin
            bps_rises    = bps_rises + 1;
            bps_rise_cyc = cyc;
        end
        if (bps_en !== 1'b1 && bps_prev === 1'b1) bps_fall_cyc = cyc;
        if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) acc_q.push_back(rx_if.rx_data);
        valid_prev = rx_if.rx_valid;
        ferr_prev  = rx_if.frame_err;
        ovr_prev   = rx_if.overrun;
        bps_prev   = bps_en;
    end

    int total = 0;
    int bad   = 0;

    // Advance n cycles; stimulus and checks happen just after the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        rx_pin = b;
        tick(BPS_PARA);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick(4);
        total++; if (bps_en !== 1'b0) begin bad++; $display("FAIL rst_bps_en got=%b exp=0", bps_en); end
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", rx_if.rx_valid); end
        total++; if (rx_if.rx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", rx_if.rx_data); end
        total++; if (rx_if.frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b exp=0", rx_if.frame_err); end
        total++; if (rx_if.overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", rx_if.overrun); end
        RST = 1'b0;
        tick(4);
    endtask

    task automatic test_frame_a5;
        int f0;
        f0 = ferr_rises;
        rx_if.rx_ready = 1'b0;
        send_frame(8'hA5, 1'b1);
        rx_pin = 1'b1;
        tick(4);
        total++; if (rx_if.rx_data !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h exp=a5", rx_if.rx_data); end
        total++; if (rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL a5_valid got=%b exp=1", rx_if.rx_valid); end
        total++; if (valid_rise_cyc - bps_fall_cyc !== 1) begin bad++; $display("FAIL a5_latency got=%0d exp=1", valid_rise_cyc - bps_fall_cyc); end
        total++; if (ferr_rises - f0 !== 0) begin bad++; $display("FAIL a5_frame_err got=%0d exp=0", ferr_rises - f0); end
        total++; if (bps_en !== 1'b0) begin bad++; $display("FAIL a5_bps_en got=%b exp=0", bps_en); end
        tick(6);
        total++; if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'hA5) begin bad++; $display("FAIL a5_hold got=%b/%h exp=1/a5", rx_if.rx_valid, rx_if.rx_data); end
        rx_if.rx_ready = 1'b1;
        tick(1);
        rx_if.rx_ready = 1'b0;
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL a5_consume got=%b exp=0", rx_if.rx_valid); end
    endtask

    task automatic test_false_start;
        int v0, b0;
        v0 = valid_rises;
        b0 = bps_rises;
        rx_pin = 1'b0;
        tick(3);
        rx_pin = 1'b1;
        tick(30);
        total++; if (valid_rises - v0 !== 0) begin bad++; $display("FAIL fs_valid got=%0d exp=0", valid_rises - v0); end
        total++; if (bps_rises - b0 !== 1) begin bad++; $display("FAIL fs_bps_starts got=%0d exp=1", bps_rises - b0); end
        total++; if (bps_fall_cyc - bps_rise_cyc !== BPS_PARA / 2 + 1) begin bad++; $display("FAIL fs_bps_len got=%0d exp=%0d", bps_fall_cyc - bps_rise_cyc, BPS_PARA / 2 + 1); end
        total++; if (bps_en !== 1'b0) begin bad++; $display("FAIL fs_bps_en got=%b exp=0", bps_en); end
    endtask

    task automatic test_frame_err;
        int v0, f0, fh0, b0;
        v0 = valid_rises; f0 = ferr_rises; fh0 = ferr_hi; b0 = bps_rises;
        rx_if.rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        tick(2 * BPS_PARA);          // line held low (break)
        total++; if (ferr_rises - f0 !== 1) begin bad++; $display("FAIL fe_pulses got=%0d exp=1", ferr_rises - f0); end
        total++; if (ferr_hi - fh0 !== 1) begin bad++; $display("FAIL fe_width got=%0d exp=1", ferr_hi - fh0); end
        total++; if (valid_rises - v0 !== 0 || rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL fe_valid got=%0d/%b exp=0/0", valid_rises - v0, rx_if.rx_valid); end
        total++; if (bps_rises - b0 !== 1 || bps_en !== 1'b0) begin bad++; $display("FAIL fe_break_start got=%0d/%b exp=1/0", bps_rises - b0, bps_en); end
        rx_pin = 1'b1;
        tick(8);
        send_frame(8'h5A, 1'b1);
        rx_pin = 1'b1;
        tick(4);
        total++; if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h5A) begin bad++; $display("FAIL fe_next got=%b/%h exp=1/5a", rx_if.rx_valid, rx_if.rx_data); end
        rx_if.rx_ready = 1'b1;
        tick(1);
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic test_overrun;
        int o0, oh0;
        o0 = ovr_rises; oh0 = ovr_hi;
        rx_if.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        rx_pin = 1'b1;
        tick(4);
        total++; if (ovr_rises - o0 !== 0) begin bad++; $display("FAIL ov_first got=%0d exp=0", ovr_rises - o0); end
        send_frame(8'h22, 1'b1);
        rx_pin = 1'b1;
        tick(4);
        total++; if (rx_if.rx_data !== 8'h11 || rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL ov_keep got=%b/%h exp=1/11", rx_if.rx_valid, rx_if.rx_data); end
        total++; if (ovr_rises - o0 !== 1 || ovr_hi - oh0 !== 1) begin bad++; $display("FAIL ov_pulse got=%0d/%0d exp=1/1", ovr_rises - o0, ovr_hi - oh0); end
        rx_if.rx_ready = 1'b1;
        tick(1);
        rx_if.rx_ready = 1'b0;
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL ov_consume got=%b exp=0", rx_if.rx_valid); end
    endtask

    task automatic test_reset_mid;
        int v0, f0, o0;
        logic [7:0] d;
        d = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_pin = d[4];
        tick(BPS_PARA / 2);
        RST = 1'b1;
        tick(2);
        total++; if (bps_en !== 1'b0 || rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL rm_ctrl got=%b/%b exp=0/0", bps_en, rx_if.rx_valid); end
        total++; if (rx_if.rx_data !== 8'h00) begin bad++; $display("FAIL rm_data got=%h exp=00", rx_if.rx_data); end
        total++; if (rx_if.frame_err !== 1'b0 || rx_if.overrun !== 1'b0) begin bad++; $display("FAIL rm_pulses got=%b/%b exp=0/0", rx_if.frame_err, rx_if.overrun); end
        v0 = valid_rises; f0 = ferr_rises; o0 = ovr_rises;
        RST = 1'b0;
        rx_pin = 1'b1;
        tick(40);
        total++; if (valid_rises - v0 !== 0 || ferr_rises - f0 !== 0 || ovr_rises - o0 !== 0) begin bad++; $display("FAIL rm_quiet got=%0d/%0d/%0d exp=0/0/0", valid_rises - v0, ferr_rises - f0, ovr_rises - o0); end
        send_frame(8'h5A, 1'b1);
        rx_pin = 1'b1;
        tick(4);
        total++; if (rx_if.rx_valid !== 1'b1 || rx_if.rx_data !== 8'h5A) begin bad++; $display("FAIL rm_next got=%b/%h exp=1/5a", rx_if.rx_valid, rx_if.rx_data); end
        rx_if.rx_ready = 1'b1;
        tick(1);
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int q0, v0, o0;
        q0 = acc_q.size(); v0 = valid_rises; o0 = ovr_rises;
        rx_if.rx_ready = 1'b1;
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        rx_pin = 1'b1;
        tick(4);
        total++; if (valid_rises - v0 !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", valid_rises - v0); end
        total++; if (acc_q.size() - q0 !== 2) begin bad++; $display("FAIL b2b_accepted got=%0d exp=2", acc_q.size() - q0); end
        else begin
            total++; if (acc_q[q0] !== 8'hFF) begin bad++; $display("FAIL b2b_first got=%h exp=ff", acc_q[q0]); end
            total++; if (acc_q[q0 + 1] !== 8'h00) begin bad++; $display("FAIL b2b_second got=%h exp=00", acc_q[q0 + 1]); end
        end
        total++; if (ovr_rises - o0 !== 0) begin bad++; $display("FAIL b2b_overrun got=%0d exp=0", ovr_rises - o0); end
        total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", rx_if.rx_valid); end
        rx_if.rx_ready = 1'b0;
    endtask

    initial begin
        rx_if.rx_ready = 1'b0;
        test_reset();
        test_frame_a5();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (8N1 framing; no parity).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx_pin  input  1  asynchronous serial line; idle high.
REQ-005 SHALL have port clk_uart  input  1  one-cycle baud tick from the baud generator, arriving at mid-bit.
REQ-006 SHALL have port bps_en  output  1  baud generator enable; high while a frame is in progress.
REQ-007 SHALL have port rx_data  output  DATA_BITS  received byte held in the output buffer.
REQ-008 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse: new byte dropped because the buffer was full.

Function
REQ-012 SHALL pass rx_pin through a 2-flop synchronizer plus one history flop; start detection uses only synchronized values.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: on synchronized falling edge (prev 1, cur 0), go to START and set bps_en the same edge.
REQ-015 START: on clk_uart, sample rx; if 1 (false start), go to IDLE and clear bps_en; if 0, go to DATA with bit index 0.
REQ-016 DATA: on each clk_uart, shift sampled bit into the shift register LSB-first and increment index; after bit DATA_BITS-1, go to STOP.
REQ-017 STOP: on clk_uart, go to IDLE and clear bps_en; sample 1 completes a frame, sample 0 pulses frame_err for 1 cycle and discards the byte.
REQ-018 Ticks arriving in IDLE SHALL be ignored; bps_en SHALL be low in IDLE only.
REQ-019 After a frame_err, a new start SHALL be detected only after rx has been sampled high at least once (break suppression).
REQ-020 A completed frame SHALL load rx_data and set rx_valid on the clock edge after the stop tick (latency 1 cycle).
REQ-021 rx_valid SHALL stay high and rx_data stable until a cycle with rx_ready high; rx_valid then clears the next edge.
REQ-022 Completion with rx_valid high and rx_ready low SHALL drop the new byte, keep old data, and pulse overrun.
REQ-023 Completion in the same cycle as rx_valid & rx_ready SHALL load the new byte, keep rx_valid high, and not pulse overrun.

Reset
REQ-024 RST high SHALL force state IDLE, bps_en 0, rx_data 0, rx_valid 0, frame_err 0, overrun 0, bit index 0, synchronizer and history flops 1.
REQ-025 RST asserted mid-frame SHALL abandon the frame with no rx_valid, frame_err or overrun; reception resumes on the next falling edge after release.

Structure
REQ-026 SHALL have FSM state encoding and the 8N1 frame constants in a shared package, uart_pkg.
REQ-027 SHALL be one module plus one natural sub-module, sync_2ff (rx synchronizer); the baud generator SHALL stay external and be connected through bps_en/clk_uart.

Verification (bench: baud generator BPS_PARA=16, clk 50 MHz)
REQ-028 Frame 0xA5, stop=1, rx_ready=0 -> rx_data=0xA5, rx_valid=1 one cycle after stop tick, frame_err=0, bps_en=0.
REQ-029 rx low 3 cycles then high -> no rx_valid; bps_en returns to 0 after the START tick.
REQ-030 Frame 0x3C, stop=0 -> frame_err 1-cycle pulse, rx_valid stays 0; a following 0x5A is not detected until rx returns high, then received.
REQ-031 Frames 0x11 then 0x22, rx_ready=0 -> rx_data=0x11, overrun pulse at 0x22 completion; after rx_ready=1 for 1 cycle, rx_valid=0.
REQ-032 RST pulse during DATA bit 4 -> all outputs at reset values; next frame 0x5A received correctly.
REQ-033 rx_ready held 1, back-to-back 0xFF then 0x00 -> two rx_valid pulses with data 0xFF, 0x00; no overrun.
